// File: rtl/lsm_pkg.sv
// Shared definitions for the LDM/STM sequencer: FSM states, instruction
// field positions, addressing-mode encodings and the word stride.
package lsm_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_XFER   = 2'd2,
    ST_FINISH = 2'd3
  } lsm_state_e;

  // Addressing modes, encoded as {P, U}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } lsm_mode_e;

  // Instruction word field positions
  localparam int unsigned IR_P        = 24;
  localparam int unsigned IR_U        = 23;
  localparam int unsigned IR_S        = 22;
  localparam int unsigned IR_W        = 21;
  localparam int unsigned IR_L        = 20;
  localparam int unsigned IR_RN_LSB   = 16;
  localparam int unsigned IR_LIST_LSB = 0;

  // Byte distance between consecutive word transfers
  localparam logic [2:0] WORD_STRIDE = 3'd4;

endpackage

// File: rtl/lsm_reg_scan.sv
// Combinational scan of a 16-bit register mask: index of the lowest set
// bit, whether any bit is set, and the number of set bits.
module lsm_reg_scan (
  input  logic [15:0] mask,
  output logic [3:0]  low_idx,
  output logic        any,
  output logic [4:0]  count
);

  // Walk from the top bit down so the lowest set bit is the last one kept
  always_comb begin
    low_idx = 4'd0;
    any     = 1'b0;
    count   = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      count = count + 5'(mask[i]);
      if (mask[i]) begin
        low_idx = 4'(i);
        any     = 1'b1;
      end else begin
        any     = any;
      end
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// Load/Store Multiple sequencer. Latches the instruction and base on an
// accepted start, walks the register list lowest-to-highest issuing one
// req/ack word transfer per register, then reports base write-back and a
// done pulse.
// Optional feature macro LSM_ABORT_EN: adds mem_abort input and aborted
// output; an abort ends the sequence early with no write-back.
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       ir,
  input  logic [ADDR_W-1:0] base,
  output logic              ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [3:0]        reg_idx,
  output logic              rf_we,
  output logic              user_bank,
  output logic              wb_en,
  output logic [3:0]        wb_reg,
  output logic [ADDR_W-1:0] wb_data,
  output logic              done
`ifdef LSM_ABORT_EN
  ,
  input  logic              mem_abort,
  output logic              aborted
`endif
);

  lsm_state_e        state_r;
  lsm_state_e        state_nx;
  lsm_mode_e         mode_r;
  logic              w_r;
  logic              l_r;
  logic [15:0]       list_r;
  logic [15:0]       mask_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] wb_data_r;
  logic [3:0]        reg_idx_r;
  logic [3:0]        wb_reg_r;
  logic              ready_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic              user_bank_r;
  logic              wb_en_r;
  logic              done_r;
  logic              wb_ok_r;

  logic              abort_s;
  logic              xfer_done_s;
  logic [15:0]       scan_in_s;
  logic [3:0]        scan_idx_s;
  logic              scan_any_s;
  logic [4:0]        scan_cnt_s;
  logic [ADDR_W-1:0] n_bytes_s;
  logic [ADDR_W-1:0] stride_s;
  logic [ADDR_W-1:0] start_addr_s;
  logic [ADDR_W-1:0] wb_data_s;
  logic              wb_ok_s;
  logic              unused_ir_s;

  // Condition and family bits are checked by the caller
  assign unused_ir_s = ^ir[31:25];

`ifdef LSM_ABORT_EN
  logic aborted_r;
  assign abort_s = mem_req_r & mem_abort;
  assign aborted = aborted_r;
`else
  assign abort_s = 1'b0;
`endif

  // A transfer completes on ack unless it is being aborted in the same cycle
  assign xfer_done_s = mem_req_r & mem_ack & ~abort_s;

  // Load write strobe follows the handshake directly so data lands on ack
  assign rf_we = xfer_done_s & l_r;

  assign ready     = ready_r;
  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign reg_idx   = reg_idx_r;
  assign user_bank = user_bank_r;
  assign wb_en     = wb_en_r;
  assign wb_reg    = wb_reg_r;
  assign wb_data   = wb_data_r;
  assign done      = done_r;

  lsm_reg_scan u_scan (
    .mask    (scan_in_s),
    .low_idx (scan_idx_s),
    .any     (scan_any_s),
    .count   (scan_cnt_s)
  );

  // Scan the full list in SETUP; otherwise scan what remains after the current bit
  always_comb begin
    if (state_r == ST_SETUP) begin
      scan_in_s = list_r;
    end else begin
      scan_in_s = mask_r & ~(16'd1 << reg_idx_r);
    end
  end

  // Start address, write-back value and write-back permission, used in SETUP
  always_comb begin
    stride_s  = {{(ADDR_W-3){1'b0}}, WORD_STRIDE};
    n_bytes_s = {{(ADDR_W-7){1'b0}}, scan_cnt_s, 2'b00};
    case (mode_r)
      MODE_IA: start_addr_s = base_r;
      MODE_IB: start_addr_s = base_r + stride_s;
      MODE_DA: start_addr_s = base_r - n_bytes_s + stride_s;
      MODE_DB: start_addr_s = base_r - n_bytes_s;
      default: start_addr_s = base_r;
    endcase
    if ((mode_r == MODE_IA) || (mode_r == MODE_IB)) begin
      wb_data_s = base_r + n_bytes_s;
    end else begin
      wb_data_s = base_r - n_bytes_s;
    end
    // A loaded base register takes priority over the write-back
    wb_ok_s = w_r & scan_any_s & ~(l_r & list_r[wb_reg_r]);
  end

  // Next-state selection
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_SETUP;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (scan_any_s) begin
          state_nx = ST_XFER;
        end else begin
          state_nx = ST_FINISH;
        end
      end
      ST_XFER: begin
        if (abort_s) begin
          state_nx = ST_FINISH;
        end else if (xfer_done_s && !scan_any_s) begin
          state_nx = ST_FINISH;
        end else begin
          state_nx = ST_XFER;
        end
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State register and registered control outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ready_r   <= 1'b1;
      mem_req_r <= 1'b0;
      done_r    <= 1'b0;
      wb_en_r   <= 1'b0;
    end else begin
      state_r   <= state_nx;
      ready_r   <= (state_nx == ST_IDLE);
      mem_req_r <= (state_nx == ST_XFER);
      done_r    <= (state_nx == ST_FINISH);
      wb_en_r   <= (state_r == ST_XFER) && (state_nx == ST_FINISH) && wb_ok_r && !abort_s;
    end
  end

`ifdef LSM_ABORT_EN
  // Abort flag accompanies the done pulse of an aborted sequence
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aborted_r <= 1'b0;
    end else begin
      aborted_r <= (state_nx == ST_FINISH) && abort_s;
    end
  end
`endif

  // Datapath: instruction capture, setup calculations and per-transfer advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r      <= MODE_DA;
      w_r         <= 1'b0;
      l_r         <= 1'b0;
      list_r      <= 16'd0;
      mask_r      <= 16'd0;
      base_r      <= '0;
      mem_addr_r  <= '0;
      wb_data_r   <= '0;
      reg_idx_r   <= 4'd0;
      wb_reg_r    <= 4'd0;
      mem_we_r    <= 1'b0;
      user_bank_r <= 1'b0;
      wb_ok_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_r      <= lsm_mode_e'({ir[IR_P], ir[IR_U]});
            w_r         <= ir[IR_W];
            l_r         <= ir[IR_L];
            list_r      <= ir[IR_LIST_LSB +: 16];
            base_r      <= base;
            wb_reg_r    <= ir[IR_RN_LSB +: 4];
            mem_we_r    <= ~ir[IR_L];
            user_bank_r <= ir[IR_S];
          end
        end
        ST_SETUP: begin
          mem_addr_r <= start_addr_s;
          wb_data_r  <= wb_data_s;
          mask_r     <= list_r;
          reg_idx_r  <= scan_idx_s;
          wb_ok_r    <= wb_ok_s;
        end
        ST_XFER: begin
          if (xfer_done_s) begin
            mask_r     <= scan_in_s;
            mem_addr_r <= mem_addr_r + stride_s;
            if (scan_any_s) begin
              reg_idx_r <= scan_idx_s;
            end
          end
        end
        ST_FINISH: begin
          wb_ok_r <= 1'b0;
        end
        default: begin
          wb_ok_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed self-checking bench for lsm_sequencer.
module tb_lsm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] ir;
  logic [31:0] base;
  logic        mem_ack;
  logic        ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  reg_idx;
  logic        rf_we;
  logic        user_bank;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        done;
`ifdef LSM_ABORT_EN
  logic        mem_abort;
  logic        aborted;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lsm_sequencer #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ir        (ir),
    .base      (base),
    .ready     (ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .reg_idx   (reg_idx),
    .rf_we     (rf_we),
    .user_bank (user_bank),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .done      (done)
`ifdef LSM_ABORT_EN
    ,
    .mem_abort (mem_abort),
    .aborted   (aborted)
`endif
  );

  // Pulse start for one edge; returns at the negedge inside the SETUP cycle
  task automatic start_seq(input logic [31:0] ir_v, input logic [31:0] base_v);
    @(negedge clk);
    start = 1'b1;
    ir    = ir_v;
    base  = base_v;
    @(negedge clk);
    start = 1'b0;
    ir    = 32'h0;
    base  = 32'h0;
  endtask

  task automatic test_reset();
    logic [79:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got = {ready, mem_req, mem_we, rf_we, wb_en, done, user_bank, mem_addr, wb_data, reg_idx, wb_reg};
    tests_run++;
    if (got !== {1'b1, 6'b0, 32'h0, 32'h0, 4'h0, 4'h0}) begin
      tests_failed++;
      $display("FAIL reset_values got %h expected %h", got, {1'b1, 6'b0, 32'h0, 32'h0, 4'h0, 4'h0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ldmia();
    logic [38:0] got;
    logic [38:0] exp;
    logic [3:0]  ei [0:2];
    ei = '{4'd1, 4'd2, 4'd4};
    mem_ack = 1'b1;
    start_seq(32'hE8B00016, 32'h1000);
    #1;
    tests_run++;
    if ({ready, mem_req} !== 2'b00) begin
      tests_failed++;
      $display("FAIL ldmia_setup got %b expected 00", {ready, mem_req});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      got = {mem_req, mem_addr, reg_idx, rf_we, mem_we};
      exp = {1'b1, 32'h1000 + 32'(i * 4), ei[i], 1'b1, 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL ldmia_xfer%0d got %h expected %h", i, got, exp);
      end
    end
    @(negedge clk); #1;
    got = {done, wb_en, wb_reg, wb_data, mem_req};
    exp = {1'b1, 1'b1, 4'd0, 32'h100C, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL ldmia_finish got %h expected %h", got, exp);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({ready, done, wb_en} !== 3'b100) begin
      tests_failed++;
      $display("FAIL ldmia_idle got %b expected 100", {ready, done, wb_en});
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_stmdb();
    logic [38:0] got;
    logic [38:0] exp;
    logic [3:0]  ei [0:1];
    ei = '{4'd4, 4'd14};
    mem_ack = 1'b1;
    start_seq(32'hE92D4010, 32'h2000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      got = {mem_req, mem_addr, reg_idx, rf_we, mem_we};
      exp = {1'b1, 32'h1FF8 + 32'(i * 4), ei[i], 1'b0, 1'b1};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL stmdb_xfer%0d got %h expected %h", i, got, exp);
      end
    end
    @(negedge clk); #1;
    got = {done, wb_en, wb_reg, wb_data, mem_req};
    exp = {1'b1, 1'b1, 4'd13, 32'h1FF8, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL stmdb_finish got %h expected %h", got, exp);
    end
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [38:0] got;
    logic [38:0] exp;
    mem_ack = 1'b0;
    start_seq(32'hE8B00016, 32'h1000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = (i == 3);
      #1;
      got = {mem_req, mem_addr, reg_idx, rf_we, mem_we};
      exp = {1'b1, 32'h1000, 4'd1, (i == 3), 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL wait_hold%0d got %h expected %h", i, got, exp);
      end
    end
    @(negedge clk); #1;
    got = {mem_req, mem_addr, reg_idx, rf_we, mem_we};
    exp = {1'b1, 32'h1004, 4'd2, 1'b1, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL wait_next got %h expected %h", got, exp);
    end
    repeat (2) @(negedge clk);
    #1;
    got = {done, wb_en, wb_reg, wb_data, mem_req};
    exp = {1'b1, 1'b1, 4'd0, 32'h100C, 1'b0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL wait_finish got %h expected %h", got, exp);
    end
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_empty_list();
    mem_ack = 1'b0;
    start_seq(32'hE8B00000, 32'h3000);
    #1;
    tests_run++;
    if ({ready, mem_req, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL empty_setup got %b expected 000", {ready, mem_req, done});
    end
    @(negedge clk); #1;
    tests_run++;
    if ({done, wb_en, mem_req} !== 3'b100) begin
      tests_failed++;
      $display("FAIL empty_done got %b expected 100", {done, wb_en, mem_req});
    end
    @(negedge clk); #1;
    tests_run++;
    if ({ready, done, mem_req} !== 3'b100) begin
      tests_failed++;
      $display("FAIL empty_idle got %b expected 100", {ready, done, mem_req});
    end
  endtask

  task automatic test_rn_in_list();
    logic [38:0] got;
    logic [38:0] exp;
    mem_ack = 1'b1;
    start_seq(32'hE8B00003, 32'h1000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      got = {mem_req, mem_addr, reg_idx, rf_we, mem_we};
      exp = {1'b1, 32'h1000 + 32'(i * 4), 4'(i), 1'b1, 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL rnlist_xfer%0d got %h expected %h", i, got, exp);
      end
    end
    @(negedge clk); #1;
    tests_run++;
    if ({done, wb_en, mem_req} !== 3'b100) begin
      tests_failed++;
      $display("FAIL rnlist_no_wb got %b expected 100", {done, wb_en, mem_req});
    end
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [37:0] got;
    logic [37:0] exp;
    bit          stray;
    mem_ack = 1'b1;
    start_seq(32'hE92D4010, 32'h2000);
    @(negedge clk);
    // start while busy, with a different instruction that sets S
    start = 1'b1;
    ir    = 32'hE8F000FF;
    base  = 32'h5000;
    #1;
    got = {mem_req, mem_addr, reg_idx, mem_we};
    exp = {1'b1, 32'h1FF8, 4'd4, 1'b1};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL rstmid_xfer0 got %h expected %h", got, exp);
    end
    @(negedge clk);
    start = 1'b0;
    ir    = 32'h0;
    base  = 32'h0;
    #1;
    got = {mem_req, mem_addr, reg_idx, mem_we};
    exp = {1'b1, 32'h1FFC, 4'd14, 1'b1};
    tests_run++;
    if ({got, user_bank} !== {exp, 1'b0}) begin
      tests_failed++;
      $display("FAIL busy_start_ignored got %h expected %h", {got, user_bank}, {exp, 1'b0});
    end
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if ({ready, mem_req, done, wb_en} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rstmid_abandon got %b expected 1000", {ready, mem_req, done, wb_en});
    end
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (done || wb_en || mem_req) stray = 1'b1;
    end
    tests_run++;
    if (stray !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_no_done got %b expected 0", stray);
    end
  endtask

`ifdef LSM_ABORT_EN
  task automatic test_abort();
    mem_ack = 1'b1;
    start_seq(32'hE8B00016, 32'h1000);
    @(negedge clk); #1;
    tests_run++;
    if ({mem_req, reg_idx, rf_we} !== {1'b1, 4'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL abort_first got %h expected %h", {mem_req, reg_idx, rf_we}, {1'b1, 4'd1, 1'b1});
    end
    @(negedge clk);
    mem_abort = 1'b1;
    #1;
    tests_run++;
    if ({mem_req, reg_idx, rf_we} !== {1'b1, 4'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL abort_no_rfwe got %h expected %h", {mem_req, reg_idx, rf_we}, {1'b1, 4'd2, 1'b0});
    end
    @(negedge clk);
    mem_abort = 1'b0;
    #1;
    tests_run++;
    if ({done, aborted, wb_en, mem_req} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL abort_finish got %b expected 1100", {done, aborted, wb_en, mem_req});
    end
    @(negedge clk); #1;
    tests_run++;
    if ({ready, aborted, mem_req} !== 3'b100) begin
      tests_failed++;
      $display("FAIL abort_idle got %b expected 100", {ready, aborted, mem_req});
    end
    mem_ack = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    ir      = 32'h0;
    base    = 32'h0;
    mem_ack = 1'b0;
`ifdef LSM_ABORT_EN
    mem_abort = 1'b0;
`endif
    test_reset();
    test_ldmia();
    test_stmdb();
    test_wait_states();
    test_empty_list();
    test_rn_in_list();
    test_reset_mid();
`ifdef LSM_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
